dcache_stall_ctrl: RTL and testbench
====================================

// Module: dcache_stall_ctrl
// PURPOSE
//  Data-cache miss sequencer for the MEM stage. Detects a MEM-stage miss and drives the
//  shared stall_o that freezes IF/ID, ID/EX, EX/MEM and MEM/WB.
//  Sequences an optional dirty write-back, then the refill, with lower memory.
//  Releases the pipeline once the refilled line hits.
// PARAMETERS
//  CNT_W           16   width of miss counter miss_cnt_o
//  TIMEOUT_CYCLES  1024 max cycles a lower-memory request may wait for ack (STALL_TIMEOUT_EN only)
// PORTS
//  clk_i        in   1      clock, rising edge
//  rst_i        in   1      reset, asynchronous, active-high
//  mem_req_i    in   1      MEM stage holds a valid load/store this cycle
//  cache_hit_i  in   1      dcache tag lookup hit (combinational, same cycle)
//  dirty_i      in   1      victim line is dirty (valid when hit=0)
//  mem_ack_i    in   1      lower memory completes current request (1-cycle pulse)
//  clr_cnt_i    in   1      synchronous clear of miss_cnt_o
//  stall_o      out  1      freeze all pipeline registers
//  mem_req_o    out  1      lower-memory request, level
//  mem_wr_o     out  1      1 = write-back of victim, 0 = refill read; valid while mem_req_o=1
//  refill_o     out  1      1-cycle pulse: write refilled line into cache, clear dirty
//  miss_cnt_o   out  CNT_W  saturating miss count
//  timeout_o    out  1      sticky: a request exceeded TIMEOUT_CYCLES
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; mem_req_o/mem_wr_o/refill_o/timeout_o=0.
//    miss_cnt_o=0 and timer=0. stall_o=0 because the state is IDLE and stall_o is
//    gated by mem_req_i. Reset mid-request abandons it with no ack wait.
//  - FSM states: IDLE, WBACK, REFILL, UPDATE. Moore outputs from registered state,
//    except stall_o in IDLE.
//  - IDLE: stall_o = mem_req_i & ~cache_hit_i.
//    On that miss: next = dirty_i ? WBACK : REFILL, and miss_cnt_o += 1.
//    mem_ack_i is ignored in IDLE.
//  - WBACK: stall_o=1, mem_req_o=1, mem_wr_o=1. On mem_ack_i -> REFILL.
//    mem_req_o stays high; the mem_wr_o 1->0 edge starts the new transaction.
//  - REFILL: stall_o=1, mem_req_o=1, mem_wr_o=0. On mem_ack_i -> UPDATE.
//  - UPDATE: stall_o=1, refill_o=1, mem_req_o=0; unconditional -> IDLE.
//    The access re-looks up, hits, and stall_o drops.
//  - Latency, clean miss with ack in request cycle k (miss detected at cycle 0):
//    stall high cycles 0..k+1, UPDATE at k+1, stall low at k+2.
//    A dirty miss adds the write-back duration.
//  - miss_cnt_o saturates at 2^CNT_W-1 (no wrap). clr_cnt_i wins over a simultaneous increment.
//  - mem_ack_i arriving together with reset: reset wins.
//  - Back-to-back misses: a new miss is accepted in the IDLE cycle right after UPDATE.
// CONFIGURATION
//  STALL_TIMEOUT_EN defined:
//   - Timer counts cycles in WBACK/REFILL; it is cleared on each state entry and on mem_ack_i.
//   - timer == TIMEOUT_CYCLES-1 without ack: set timeout_o (sticky until reset),
//     force the FSM to IDLE, drop mem_req_o and release stall.
//  STALL_TIMEOUT_EN undefined: no timer logic; timeout_o tied 0; the FSM waits on ack indefinitely.
// STRUCTURE
//  Shared package pipe_ctrl_pkg: state encoding localparams (IDLE=2'd0, WBACK=2'd1, REFILL=2'd2,
//  UPDATE=2'd3) and the default CNT_W. One sub-module: stall_timer (load/clear/terminal-count
//  counter), instantiated only under STALL_TIMEOUT_EN. Miss counter and FSM stay inline.
// TESTING
//  1 Hit: mem_req_i=1, cache_hit_i=1 for 10 cycles -> stall_o=0 throughout, miss_cnt_o=0.
//  2 Clean miss, ack 5 cycles after mem_req_o rises:
//    -> stall_o high 7 cycles, mem_wr_o=0, one refill_o pulse, miss_cnt_o=1.
//  3 Dirty miss, acks at 3 and 4 cycles:
//    -> WBACK (mem_wr_o=1) then REFILL (mem_wr_o=0), mem_req_o continuous, stall_o 9 cycles.
//  4 rst_i pulsed while in REFILL -> same cycle: mem_req_o=0, stall_o=0, miss_cnt_o=0;
//    a later stray mem_ack_i is ignored.
//  5 CNT_W=2: 5 misses -> miss_cnt_o=3. clr_cnt_i together with a 6th miss -> miss_cnt_o=0.
//  6 STALL_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> after 8 request cycles timeout_o=1,
//    FSM in IDLE, mem_req_o=0, and timeout_o stays 1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: sequencer state encoding and default widths.
package pipe_ctrl_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WBACK  = 2'd1;
    localparam logic [1:0] REFILL = 2'd2;
    localparam logic [1:0] UPDATE = 2'd3;

    localparam int CNT_W_DEFAULT = 16;

    // Counter width able to hold cycles-1; never narrower than one bit.
    function automatic int tmr_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/dcache_stall_ctrl_if.sv
// Pipeline/lower-memory handshake bundle of the data-cache miss sequencer.
interface dcache_stall_ctrl_if;

    logic mem_req_i;
    logic cache_hit_i;
    logic dirty_i;
    logic mem_ack_i;
    logic stall_o;
    logic mem_req_o;
    logic mem_wr_o;
    logic refill_o;

    // master: the pipeline and lower memory around the sequencer
    modport master (
        output mem_req_i, cache_hit_i, dirty_i, mem_ack_i,
        input  stall_o, mem_req_o, mem_wr_o, refill_o
    );

    // slave: the miss sequencer itself
    modport slave (
        input  mem_req_i, cache_hit_i, dirty_i, mem_ack_i,
        output stall_o, mem_req_o, mem_wr_o, refill_o
    );

endinterface

// File: rtl/stall_timer.sv
// Request-wait down-counter with load and terminal-count flag.
// Only built with STALL_TIMEOUT_EN; the default build has no timer at all.
`ifdef STALL_TIMEOUT_EN
module stall_timer #(
    parameter int W = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule
`endif

// File: rtl/dcache_stall_ctrl.sv
// Data-cache miss sequencer: stalls the pipeline, runs write-back/refill with lower memory.
// Optional request timeout enabled by defining STALL_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no miss in flight; stall follows the live lookup
// WBACK  | writing the dirty victim line to lower memory
// REFILL | reading the missing line from lower memory
// UPDATE | one cycle writing the refilled line into the cache
module dcache_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    dcache_stall_ctrl_if.slave bus,
    input  logic               clr_cnt_i,
    output logic [CNT_W-1:0]   miss_cnt_o,
    output logic               timeout_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             miss;
    logic             req_active;
    logic             tmr_tc;
    logic [CNT_W-1:0] miss_cnt_q;

    assign req_active = (state_q == WBACK) || (state_q == REFILL);
    assign miss       = (state_q == IDLE) && bus.mem_req_i && !bus.cache_hit_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (miss) begin
                    state_d = bus.dirty_i ? WBACK : REFILL;
                end
            end
            WBACK: begin
                if (bus.mem_ack_i) begin
                    state_d = REFILL;
                end else if (tmr_tc) begin
                    state_d = IDLE;
                end
            end
            REFILL: begin
                if (bus.mem_ack_i) begin
                    state_d = UPDATE;
                end else if (tmr_tc) begin
                    state_d = IDLE;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Only IDLE looks at the live lookup; every other state holds the pipeline.
    assign bus.stall_o   = (state_q == IDLE) ? (bus.mem_req_i & ~bus.cache_hit_i) : 1'b1;
    assign bus.mem_req_o = req_active;
    assign bus.mem_wr_o  = (state_q == WBACK);
    assign bus.refill_o  = (state_q == UPDATE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            miss_cnt_q <= '0;
        end else if (clr_cnt_i) begin
            miss_cnt_q <= '0;
        end else if (miss && (miss_cnt_q != CNT_MAX)) begin
            miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    assign miss_cnt_o = miss_cnt_q;

`ifdef STALL_TIMEOUT_EN
    localparam int             TMR_W    = tmr_width(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    logic tmr_zero;
    logic timeout_q;

    // Reloaded while idle and on every ack, so each request gets a full window.
    stall_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (!req_active || bus.mem_ack_i),
        .load_val_i (TMR_LOAD),
        .zero_o     (tmr_zero)
    );

    assign tmr_tc = req_active && !bus.mem_ack_i && tmr_zero;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timeout_q <= 1'b0;
        end else if (tmr_tc) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign tmr_tc    = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_stall_ctrl.sv
// Directed bench for dcache_stall_ctrl; timeout scenario runs when STALL_TIMEOUT_EN is defined.
module tb_dcache_stall_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       clr_cnt_i;
    logic [1:0] miss_cnt_o;
    logic       timeout_o;
    int         n_pass  = 0;
    int         n_total = 0;

    always #5 clk_i = ~clk_i;

    dcache_stall_ctrl_if bus ();

    dcache_stall_ctrl #(
        .CNT_W          (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bus        (bus),
        .clr_cnt_i  (clr_cnt_i),
        .miss_cnt_o (miss_cnt_o),
        .timeout_o  (timeout_o)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_req_i   = 1'b0;
        bus.cache_hit_i = 1'b0;
        bus.dirty_i     = 1'b0;
        bus.mem_ack_i   = 1'b0;
        clr_cnt_i       = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_i = 1'b1;
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
    endtask

    // Clean miss acked in its first request cycle, followed by one idle cycle.
    task automatic do_clean_miss();
        bus.mem_req_i = 1'b1; bus.cache_hit_i = 1'b0; bus.dirty_i = 1'b0; bus.mem_ack_i = 1'b0;
        next_cycle();
        bus.mem_ack_i = 1'b1;
        next_cycle();
        bus.mem_ack_i = 1'b0; bus.cache_hit_i = 1'b1;
        next_cycle();
        bus.mem_req_i = 1'b0; bus.cache_hit_i = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst_i = 1'b1;
        #1;
        n_total++;
        if ({bus.stall_o, bus.mem_req_o, bus.mem_wr_o, bus.refill_o, timeout_o} !== 5'b0) begin
            $display("FAIL reset_outputs: got %b expected 00000",
                     {bus.stall_o, bus.mem_req_o, bus.mem_wr_o, bus.refill_o, timeout_o});
        end else n_pass++;
        n_total++;
        if (miss_cnt_o !== 2'd0) $display("FAIL reset_miss_cnt: got %0d expected 0", miss_cnt_o);
        else n_pass++;
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
    endtask

    task automatic test_hit();
        int stall_n = 0;
        int req_n   = 0;
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            bus.mem_req_i   = 1'b1;
            bus.cache_hit_i = 1'b1;
            bus.mem_ack_i   = (c == 3);
            @(negedge clk_i);
            stall_n += int'(bus.stall_o);
            req_n   += int'(bus.mem_req_o);
            next_cycle();
        end
        idle_inputs();
        n_total++;
        if (stall_n !== 0) $display("FAIL hit_stall: got %0d stall cycles expected 0", stall_n);
        else n_pass++;
        n_total++;
        if (req_n !== 0) $display("FAIL hit_mem_req: got %0d request cycles expected 0", req_n);
        else n_pass++;
        n_total++;
        if (miss_cnt_o !== 2'd0) $display("FAIL hit_miss_cnt: got %0d expected 0", miss_cnt_o);
        else n_pass++;
    endtask

    task automatic test_clean_miss();
        int stall_n   = 0;
        int req_n     = 0;
        int wr_n      = 0;
        int refill_n  = 0;
        int refill_at = -1;
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            bus.mem_req_i   = 1'b1;
            bus.cache_hit_i = (c >= 6);
            bus.dirty_i     = 1'b0;
            bus.mem_ack_i   = (c == 5);
            @(negedge clk_i);
            stall_n += int'(bus.stall_o);
            if (bus.mem_req_o) begin
                req_n++;
                wr_n += int'(bus.mem_wr_o);
            end
            if (bus.refill_o) begin
                refill_n++;
                refill_at = c;
            end
            next_cycle();
        end
        idle_inputs();
        n_total++;
        if (stall_n !== 7) $display("FAIL clean_stall_len: got %0d expected 7", stall_n);
        else n_pass++;
        n_total++;
        if (req_n !== 5) $display("FAIL clean_req_len: got %0d expected 5", req_n);
        else n_pass++;
        n_total++;
        if (wr_n !== 0) $display("FAIL clean_mem_wr: got %0d write cycles expected 0", wr_n);
        else n_pass++;
        n_total++;
        if (refill_n !== 1 || refill_at !== 6)
            $display("FAIL clean_refill: got %0d pulses at cycle %0d expected 1 at 6", refill_n, refill_at);
        else n_pass++;
        n_total++;
        if (miss_cnt_o !== 2'd1) $display("FAIL clean_miss_cnt: got %0d expected 1", miss_cnt_o);
        else n_pass++;
    endtask

    task automatic test_dirty_miss();
        int stall_n   = 0;
        int wr1_n     = 0;
        int wr0_n     = 0;
        int req_first = -1;
        int req_last  = -1;
        int req_n     = 0;
        int refill_at = -1;
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            bus.mem_req_i   = 1'b1;
            bus.cache_hit_i = (c >= 8);
            bus.dirty_i     = (c == 0);
            bus.mem_ack_i   = (c == 3) || (c == 7);
            @(negedge clk_i);
            stall_n += int'(bus.stall_o);
            if (bus.mem_req_o) begin
                req_n++;
                if (req_first < 0) req_first = c;
                req_last = c;
                if (bus.mem_wr_o) wr1_n++;
                else begin
                    wr0_n++;
                    if (wr1_n != 3) wr1_n = 100;
                end
            end
            if (bus.refill_o) refill_at = c;
            next_cycle();
        end
        idle_inputs();
        n_total++;
        if (stall_n !== 9) $display("FAIL dirty_stall_len: got %0d expected 9", stall_n);
        else n_pass++;
        n_total++;
        if (wr1_n !== 3 || wr0_n !== 4)
            $display("FAIL dirty_wr_phases: got wb=%0d rd=%0d expected wb=3 rd=4", wr1_n, wr0_n);
        else n_pass++;
        n_total++;
        if (req_n !== 7 || req_first !== 1 || req_last !== 7)
            $display("FAIL dirty_req_continuous: got %0d cycles %0d..%0d expected 7 cycles 1..7",
                     req_n, req_first, req_last);
        else n_pass++;
        n_total++;
        if (refill_at !== 8) $display("FAIL dirty_refill_at: got %0d expected 8", refill_at);
        else n_pass++;
        n_total++;
        if (miss_cnt_o !== 2'd1) $display("FAIL dirty_miss_cnt: got %0d expected 1", miss_cnt_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid_request();
        int bad_n = 0;
        apply_reset();
        bus.mem_req_i = 1'b1; bus.cache_hit_i = 1'b0;
        next_cycle();
        next_cycle();
        n_total++;
        if (bus.mem_req_o !== 1'b1) $display("FAIL rstmid_in_refill: got mem_req_o=%b expected 1", bus.mem_req_o);
        else n_pass++;
        #2;
        rst_i = 1'b1; bus.mem_req_i = 1'b0; bus.mem_ack_i = 1'b1;
        #1;
        n_total++;
        if ({bus.mem_req_o, bus.stall_o} !== 2'b00)
            $display("FAIL rstmid_outputs: got req/stall=%b expected 00", {bus.mem_req_o, bus.stall_o});
        else n_pass++;
        n_total++;
        if (miss_cnt_o !== 2'd0) $display("FAIL rstmid_miss_cnt: got %0d expected 0", miss_cnt_o);
        else n_pass++;
        next_cycle();
        rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.mem_ack_i = (c == 0);
            @(negedge clk_i);
            if (bus.mem_req_o || bus.refill_o || bus.stall_o) bad_n++;
            next_cycle();
        end
        idle_inputs();
        n_total++;
        if (bad_n !== 0) $display("FAIL rstmid_stray_ack: got %0d active cycles expected 0", bad_n);
        else n_pass++;
    endtask

    task automatic test_miss_counter();
        apply_reset();
        do_clean_miss();
        n_total++;
        if (miss_cnt_o !== 2'd1) $display("FAIL cnt_first: got %0d expected 1", miss_cnt_o);
        else n_pass++;
        for (int i = 0; i < 4; i++) do_clean_miss();
        n_total++;
        if (miss_cnt_o !== 2'd3) $display("FAIL cnt_saturate: got %0d expected 3", miss_cnt_o);
        else n_pass++;
        bus.mem_req_i = 1'b1; bus.cache_hit_i = 1'b0; clr_cnt_i = 1'b1;
        next_cycle();
        clr_cnt_i = 1'b0;
        n_total++;
        if (miss_cnt_o !== 2'd0) $display("FAIL cnt_clear_wins: got %0d expected 0", miss_cnt_o);
        else n_pass++;
        n_total++;
        if (bus.mem_req_o !== 1'b1) $display("FAIL cnt_clear_miss_taken: got mem_req_o=%b expected 1", bus.mem_req_o);
        else n_pass++;
        bus.mem_ack_i = 1'b1;
        next_cycle();
        bus.mem_ack_i = 1'b0; bus.cache_hit_i = 1'b1;
        next_cycle();
        bus.mem_req_i = 1'b0; bus.cache_hit_i = 1'b0;
        next_cycle();
        do_clean_miss();
        n_total++;
        if (miss_cnt_o !== 2'd1) $display("FAIL cnt_after_clear: got %0d expected 1", miss_cnt_o);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        bus.mem_req_i = 1'b1; bus.cache_hit_i = 1'b0; bus.dirty_i = 1'b0;
        next_cycle();
        bus.mem_ack_i = 1'b1;
        next_cycle();
        bus.mem_ack_i = 1'b0;
        next_cycle();
        bus.dirty_i = 1'b1;
        @(negedge clk_i);
        n_total++;
        if ({bus.stall_o, bus.refill_o, bus.mem_req_o} !== 3'b100)
            $display("FAIL b2b_new_miss: got stall/refill/req=%b expected 100",
                     {bus.stall_o, bus.refill_o, bus.mem_req_o});
        else n_pass++;
        next_cycle();
        bus.dirty_i = 1'b0; bus.mem_ack_i = 1'b1;
        @(negedge clk_i);
        n_total++;
        if ({bus.mem_req_o, bus.mem_wr_o} !== 2'b11 || miss_cnt_o !== 2'd2)
            $display("FAIL b2b_wback: got req/wr=%b cnt=%0d expected 11 cnt=2",
                     {bus.mem_req_o, bus.mem_wr_o}, miss_cnt_o);
        else n_pass++;
        next_cycle();
        @(negedge clk_i);
        n_total++;
        if ({bus.mem_req_o, bus.mem_wr_o} !== 2'b10)
            $display("FAIL b2b_refill: got req/wr=%b expected 10", {bus.mem_req_o, bus.mem_wr_o});
        else n_pass++;
        next_cycle();
        bus.mem_ack_i = 1'b0; bus.cache_hit_i = 1'b1;
        @(negedge clk_i);
        n_total++;
        if (bus.refill_o !== 1'b1) $display("FAIL b2b_update: got refill_o=%b expected 1", bus.refill_o);
        else n_pass++;
        next_cycle();
        @(negedge clk_i);
        n_total++;
        if (bus.stall_o !== 1'b0) $display("FAIL b2b_release: got stall_o=%b expected 0", bus.stall_o);
        else n_pass++;
        next_cycle();
        idle_inputs();
    endtask

`ifdef STALL_TIMEOUT_EN
    task automatic test_timeout();
        int req_n = 0;
        logic to_c8 = 1'b1;
        logic [2:0] c9 = 3'b111;
        apply_reset();
        for (int c = 0; c < 15; c++) begin
            bus.mem_req_i   = (c < 9);
            bus.cache_hit_i = 1'b0;
            @(negedge clk_i);
            req_n += int'(bus.mem_req_o);
            if (c == 8) to_c8 = timeout_o;
            if (c == 9) c9 = {timeout_o, bus.mem_req_o, bus.stall_o};
            next_cycle();
        end
        idle_inputs();
        n_total++;
        if (req_n !== 8) $display("FAIL to_req_len: got %0d expected 8", req_n);
        else n_pass++;
        n_total++;
        if (to_c8 !== 1'b0) $display("FAIL to_early: got timeout_o=%b at cycle 8 expected 0", to_c8);
        else n_pass++;
        n_total++;
        if (c9 !== 3'b100) $display("FAIL to_abort: got timeout/req/stall=%b expected 100", c9);
        else n_pass++;
        n_total++;
        if (timeout_o !== 1'b1) $display("FAIL to_sticky: got %b expected 1", timeout_o);
        else n_pass++;
        apply_reset();
        n_total++;
        if (timeout_o !== 1'b0) $display("FAIL to_reset_clears: got %b expected 0", timeout_o);
        else n_pass++;
    endtask
`else
    task automatic test_no_timeout();
        int req_n = 0;
        apply_reset();
        for (int c = 0; c < 40; c++) begin
            bus.mem_req_i   = 1'b1;
            bus.cache_hit_i = 1'b0;
            @(negedge clk_i);
            req_n += int'(bus.mem_req_o);
            next_cycle();
        end
        n_total++;
        if (req_n !== 39 || timeout_o !== 1'b0)
            $display("FAIL nto_waits: got %0d request cycles timeout=%b expected 39 and 0", req_n, timeout_o);
        else n_pass++;
        bus.mem_ack_i = 1'b1;
        next_cycle();
        bus.mem_ack_i = 1'b0; bus.cache_hit_i = 1'b1;
        @(negedge clk_i);
        n_total++;
        if (bus.refill_o !== 1'b1) $display("FAIL nto_refill: got %b expected 1", bus.refill_o);
        else n_pass++;
        next_cycle();
        idle_inputs();
    endtask
`endif

    initial begin
        rst_i = 1'b0;
        idle_inputs();
        next_cycle();
        test_reset();
        test_hit();
        test_clean_miss();
        test_dirty_miss();
        test_reset_mid_request();
        test_miss_counter();
        test_back_to_back();
`ifdef STALL_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
